// File: rtl/mux_16b3_if.sv
// Operand-mux bus: three data inputs, select code, registered result and status.
// With MUX16B3_SEL_ERR_EN defined the bus also carries the sticky sel_err flag.
interface mux_16b3_if #(
    parameter int WIDTH = 16
);
    logic [WIDTH-1:0] in0;
    logic [WIDTH-1:0] in1;
    logic [WIDTH-1:0] in2;
    logic [1:0]       set;
    logic [WIDTH-1:0] out;
    logic             out_valid;
`ifdef MUX16B3_SEL_ERR_EN
    logic             sel_err;
`endif

    modport master (
        output in0, in1, in2, set,
        input  out, out_valid
`ifdef MUX16B3_SEL_ERR_EN
        , input sel_err
`endif
    );

    modport slave (
        input  in0, in1, in2, set,
        output out, out_valid
`ifdef MUX16B3_SEL_ERR_EN
        , output sel_err
`endif
    );
endinterface

// File: rtl/mux_16b3.sv
// Registered 3-way operand selector with hold code (set=3), single-cycle latency.
// Optional feature macro MUX16B3_SEL_ERR_EN adds a sticky sel_err flag for set=3.
module mux_16b3 #(
    parameter int               WIDTH     = 16,
    parameter logic [WIDTH-1:0] RESET_VAL = {WIDTH{1'b0}}
) (
    input  logic       clk,
    input  logic       rst_n,
    mux_16b3_if.slave  bus
);

    logic [WIDTH-1:0] next_data_s;
    logic             load_s;
    logic [WIDTH-1:0] out_r;
    logic             out_valid_r;

    // Select decode; code 3 and any unknown select fall through to hold.
    always_comb begin
        next_data_s = out_r;
        load_s      = 1'b0;
        case (bus.set)
            2'd0: begin
                next_data_s = bus.in0;
                load_s      = 1'b1;
            end
            2'd1: begin
                next_data_s = bus.in1;
                load_s      = 1'b1;
            end
            2'd2: begin
                next_data_s = bus.in2;
                load_s      = 1'b1;
            end
            default: begin
                next_data_s = out_r;
                load_s      = 1'b0;
            end
        endcase
    end

    // Output data and validity registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_r       <= RESET_VAL;
            out_valid_r <= 1'b0;
        end else if (load_s) begin
            out_r       <= next_data_s;
            out_valid_r <= 1'b1;
        end else begin
            out_r       <= out_r;
            out_valid_r <= out_valid_r;
        end
    end

    assign bus.out       = out_r;
    assign bus.out_valid = out_valid_r;

`ifdef MUX16B3_SEL_ERR_EN
    logic sel_err_r;
    logic hold_code_s;

    assign hold_code_s = (bus.set == 2'd3);

    // Sticky flag: once a hold code is seen it stays set until reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sel_err_r <= 1'b0;
        end else if (hold_code_s) begin
            sel_err_r <= 1'b1;
        end else begin
            sel_err_r <= sel_err_r;
        end
    end

    assign bus.sel_err = sel_err_r;
`endif

endmodule

// File: tb/tb_mux_16b3.sv
// Directed bench for mux_16b3: hand-written reset/latency/hold/async-reset
// sequences followed by a table of full-width select vectors.
module tb_mux_16b3;

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_fail;

    mux_16b3_if #(.WIDTH(16)) bus ();

    mux_16b3 #(
        .WIDTH     (16),
        .RESET_VAL (16'h0000)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    typedef struct {
        string       name;
        logic [1:0]  set;
        logic [15:0] in0;
        logic [15:0] in1;
        logic [15:0] in2;
        logic [15:0] exp_out;
        logic        exp_valid;
    } vec_t;

    vec_t vecs [9];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_checks = n_checks + 1;
        if (act !== exp) begin
            n_fail = n_fail + 1;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_state(input string name, input logic [15:0] exp_out, input logic exp_valid);
        check({name, "_out"}, bus.out, exp_out);
        check({name, "_valid"}, {15'd0, bus.out_valid}, {15'd0, exp_valid});
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;

        vecs[0] = '{"fw_sel0",     2'd0, 16'hA5A5, 16'h5A5A, 16'hFFFF, 16'hA5A5, 1'b1};
        vecs[1] = '{"fw_sel1",     2'd1, 16'hA5A5, 16'h5A5A, 16'hFFFF, 16'h5A5A, 1'b1};
        vecs[2] = '{"fw_sel2",     2'd2, 16'hA5A5, 16'h5A5A, 16'hFFFF, 16'hFFFF, 1'b1};
        vecs[3] = '{"fw_hold",     2'd3, 16'hA5A5, 16'h5A5A, 16'h0000, 16'hFFFF, 1'b1};
        vecs[4] = '{"sel0_small",  2'd0, 16'h0001, 16'h8000, 16'h0000, 16'h0001, 1'b1};
        vecs[5] = '{"unsel_chg",   2'd0, 16'h0001, 16'h1234, 16'h4321, 16'h0001, 1'b1};
        vecs[6] = '{"sel1_msb",    2'd1, 16'h0001, 16'h8000, 16'h4321, 16'h8000, 1'b1};
        vecs[7] = '{"sel2_mixed",  2'd2, 16'h0001, 16'h8000, 16'h7FFE, 16'h7FFE, 1'b1};
        vecs[8] = '{"hold_in0chg", 2'd3, 16'hFFFF, 16'h8000, 16'h7FFE, 16'h7FFE, 1'b1};

        // Reset asserted with data present: outputs cleared without a clock.
        rst_n   = 1'b0;
        bus.in0 = 16'd1;
        bus.in1 = 16'd3;
        bus.in2 = 16'd7;
        bus.set = 2'd0;
        #1;
        check_state("reset_imm", 16'h0000, 1'b0);
`ifdef MUX16B3_SEL_ERR_EN
        check("reset_selerr", {15'd0, bus.sel_err}, 16'd0);
`endif
        for (int i = 0; i < 2; i++) begin
            @(posedge clk); #1;
            check_state("reset_hold", 16'h0000, 1'b0);
        end

        // Release and select in0.
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        check_state("sel0", 16'd1, 1'b1);

        // Sweep with latency proof: old value still present before the edge.
        @(negedge clk);
        bus.set = 2'd1;
        #1;
        check_state("lat_pre1", 16'd1, 1'b1);
        @(posedge clk); #1;
        check_state("sel1", 16'd3, 1'b1);
        @(negedge clk);
        bus.set = 2'd2;
        #1;
        check_state("lat_pre2", 16'd3, 1'b1);
        @(posedge clk); #1;
        check_state("sel2", 16'd7, 1'b1);

        // Hold code while the (nominally selected) in2 changes.
        @(negedge clk);
        bus.set = 2'd3;
        @(posedge clk); #1;
        check_state("hold0", 16'd7, 1'b1);
`ifdef MUX16B3_SEL_ERR_EN
        check("hold_selerr", {15'd0, bus.sel_err}, 16'd1);
`endif
        @(negedge clk);
        bus.in2 = 16'hFFFF;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            check_state("hold_in2chg", 16'd7, 1'b1);
        end

        // Return to in0, then async reset pulse between edges.
        @(negedge clk);
        bus.set = 2'd0;
        @(posedge clk); #1;
        check_state("return0", 16'd1, 1'b1);
`ifdef MUX16B3_SEL_ERR_EN
        check("selerr_sticky", {15'd0, bus.sel_err}, 16'd1);
`endif
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check_state("async_rst", 16'h0000, 1'b0);
`ifdef MUX16B3_SEL_ERR_EN
        check("async_selerr", {15'd0, bus.sel_err}, 16'd0);
`endif

        // Only hold codes after reset: output stays at reset value, invalid.
        bus.set = 2'd3;
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 2; i++) begin
            @(posedge clk); #1;
            check_state("hold_after_rst", 16'h0000, 1'b0);
        end

        // Table-driven full-width vectors.
        for (int i = 0; i < 9; i++) begin
            @(negedge clk);
            bus.set = vecs[i].set;
            bus.in0 = vecs[i].in0;
            bus.in1 = vecs[i].in1;
            bus.in2 = vecs[i].in2;
            @(posedge clk); #1;
            check_state(vecs[i].name, vecs[i].exp_out, vecs[i].exp_valid);
        end
`ifdef MUX16B3_SEL_ERR_EN
        check("table_selerr", {15'd0, bus.sel_err}, 16'd1);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mux_16b3.md
Name: mux_16b3

Overview:
- Registered 3-way, 16-bit data selector for the datapath: picks one of in0/in1/in2 by a 2-bit select and presents it on a registered output.
- Select code 3 is a defined "hold" code: the output keeps its previous value.
- Sits ahead of ALU/register-file operand inputs where a single-cycle-latency operand mux is needed.

Parameters:
- WIDTH, 16, data width of in0/in1/in2/out.
- RESET_VAL, 0, value loaded into out on reset (WIDTH bits).

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- in0  input  WIDTH  data input selected by set=0.
- in1  input  WIDTH  data input selected by set=1.
- in2  input  WIDTH  data input selected by set=2.
- set  input  2  select code: 0→in0, 1→in1, 2→in2, 3→hold.
- out  output  WIDTH  registered selected data.
- out_valid  output  1  high when out holds data loaded from an input since reset.
- sel_err  output  1  sticky invalid-select flag; exists only with SEL_ERR_EN (see Optional Feature).

Behaviour:
- Reset: rst_n low forces out=RESET_VAL and out_valid=0 immediately, with no clock needed. sel_err=0 when present. Release takes effect at the next rising clk edge.
- Latency: 1 cycle. The values of set and inN sampled at rising edge k appear on out after edge k.
- Select decode on each rising edge (rst_n high):
  - set=0: out<=in0, out_valid<=1.
  - set=1: out<=in1, out_valid<=1.
  - set=2: out<=in2, out_valid<=1.
  - set=3: out and out_valid keep their values. This is a no-op, not an error in the base build.
- Data inputs that are not selected have no effect. Changing an unselected input never changes out.
- No arithmetic. Full WIDTH bits are passed unmodified; no truncation or extension.
- out_valid stays 0 if only set=3 is applied after reset. out then remains RESET_VAL.
- Reset asserted mid-operation overrides any select in the same cycle. Reset has priority over the clock.
- X/Z on set: treated as hold for synthesis purposes. The verification bench must not drive X after reset.
- No internal state besides out, out_valid and (optionally) sel_err. No state machine.

Optional Feature:
- Macro: MUX16B3_SEL_ERR_EN.
- Defined:
  - Port sel_err is present.
  - sel_err is set to 1 on any rising edge where rst_n=1 and set=3, and stays 1 until rst_n goes low.
  - Hold behaviour on out/out_valid is unchanged.
- Not defined:
  - sel_err port is absent.
  - Select code 3 is silently a hold.
  - All other behaviour is identical.

Test Plan:
- Reset: rst_n=0 with in0=1, in1=3, in2=7, set=0 → out=0 and out_valid=0 immediately. Hold for 2 clocks with no change.
- Select 0: release reset, in0=1, in1=3, in2=7, set=0 → after the next edge out=1, out_valid=1.
- Select sweep: set=1 → out=3 one cycle later; set=2 → out=7 one cycle later. Prove 1-cycle latency by checking out is still the previous value before the edge.
- Hold: from out=7, set=3, then change in2 to 16'hFFFF → out stays 7 for 3 cycles. With MUX16B3_SEL_ERR_EN, sel_err=1 after the first edge.
- Return and async reset: set=0 → out=1. Then pulse rst_n low between clock edges → out=0, out_valid=0 (and sel_err=0) without a clock edge.
- Full-width check: in0=16'hA5A5, in1=16'h5A5A, in2=16'hFFFF, cycle set 0,1,2 → out matches each exactly, with no bit loss.
